// File: rtl/peak_dpu_fetch_align.sv
// Fetch-alignment buffer: queues 32-bit fetch words as halfwords and
// presents one 16- or 32-bit RISC-V instruction per cycle to decode.
module peak_dpu_fetch_align #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_vld,
    output logic        fetch_rdy,
    input  logic [31:0] fetch_data,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        instr0_vld,
    output logic [31:0] instr0_op,
    output logic        instr0_is_compressed,
    output logic [31:0] instr0_pc,
    input  logic        instr0_rdy
);

    localparam int NHW = 2 * DEPTH;
    localparam int PW  = $clog2(NHW);
    localparam int CW  = PW + 1;

    logic [15:0]   mem_q [NHW];
    logic [15:0]   mem_d [NHW];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] hw_cnt_q, hw_cnt_d;
    logic          skip_lo_q, skip_lo_d;
    logic [31:0]   pc_q, pc_d;

    logic [15:0]   h0, h1;
    logic          head_c;
    logic [CW-1:0] need;
    logic          enq, deq;
    logic [CW-1:0] enq_n, deq_n;

    always_comb begin
        h0        = mem_q[rd_ptr_q];
        h1        = mem_q[rd_ptr_q + PW'(1)];
        head_c    = (h0[1:0] != 2'b11);
        need      = head_c ? CW'(1) : CW'(2);
        fetch_rdy = (hw_cnt_q <= CW'(NHW - 2));
        instr0_vld           = !flush && (hw_cnt_q >= need);
        instr0_op            = '0;
        instr0_is_compressed = 1'b0;
        instr0_pc            = pc_q;
        if (instr0_vld) begin
            instr0_is_compressed = head_c;
            instr0_op = head_c ? {16'h0000, h0} : {h1, h0};
        end
    end

    assign enq = fetch_vld && fetch_rdy && !flush;
    assign deq = instr0_vld && instr0_rdy;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        hw_cnt_d  = hw_cnt_q;
        skip_lo_d = skip_lo_q;
        pc_d      = pc_q;
        enq_n     = '0;
        deq_n     = '0;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            hw_cnt_d  = '0;
            pc_d      = flush_pc;
            skip_lo_d = flush_pc[1];
        end else begin
            if (enq) begin
                // A redirect into the upper halfword drops the lower one once.
                if (skip_lo_q) begin
                    mem_d[wr_ptr_q] = fetch_data[31:16];
                    enq_n           = CW'(1);
                    skip_lo_d       = 1'b0;
                end else begin
                    mem_d[wr_ptr_q]          = fetch_data[15:0];
                    mem_d[wr_ptr_q + PW'(1)] = fetch_data[31:16];
                    enq_n                    = CW'(2);
                end
            end
            if (deq) begin
                deq_n = need;
            end
            wr_ptr_d = wr_ptr_q + enq_n[PW-1:0];
            rd_ptr_d = rd_ptr_q + deq_n[PW-1:0];
            hw_cnt_d = hw_cnt_q + enq_n - deq_n;
            pc_d     = pc_q + (32'(deq_n) << 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NHW; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            hw_cnt_q  <= '0;
            skip_lo_q <= 1'b0;
            pc_q      <= RESET_PC;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            hw_cnt_q  <= hw_cnt_d;
            skip_lo_q <= skip_lo_d;
            pc_q      <= pc_d;
        end
    end

endmodule

// File: tb/tb_peak_dpu_fetch_align.sv
// Bench for peak_dpu_fetch_align: directed vector table, async reset
// sequence, and randomized traffic against a halfword-queue model.
module tb_peak_dpu_fetch_align;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_vld;
    logic        fetch_rdy;
    logic [31:0] fetch_data;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr0_vld;
    logic [31:0] instr0_op;
    logic        instr0_is_compressed;
    logic [31:0] instr0_pc;
    logic        instr0_rdy;

    peak_dpu_fetch_align #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fetch_vld            (fetch_vld),
        .fetch_rdy            (fetch_rdy),
        .fetch_data           (fetch_data),
        .flush                (flush),
        .flush_pc             (flush_pc),
        .instr0_vld           (instr0_vld),
        .instr0_op            (instr0_op),
        .instr0_is_compressed (instr0_is_compressed),
        .instr0_pc            (instr0_pc),
        .instr0_rdy           (instr0_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        fv;
        logic [31:0] fd;
        logic [31:0] fpc;
        logic        rdy;
        logic        ev;
        logic [31:0] eop;
        logic        ec;
        logic [31:0] epc;
        logic        efr;
    } vec_t;

    vec_t tbl[$];
    int   passed = 0;
    int   total  = 0;

    logic [15:0] mq[$];
    logic [31:0] mpc;
    logic        mskip;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic fl, input logic fv, input logic [31:0] fd,
                         input logic [31:0] fpc, input logic rdy);
        flush      = fl;
        fetch_vld  = fv;
        fetch_data = fd;
        flush_pc   = fpc;
        instr0_rdy = rdy;
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] eop,
                           input logic ec, input logic [31:0] epc, input logic efr);
        chk({tag, ".vld"}, {31'd0, instr0_vld}, {31'd0, ev});
        chk({tag, ".op"}, instr0_op, eop);
        chk({tag, ".c"}, {31'd0, instr0_is_compressed}, {31'd0, ec});
        chk({tag, ".pc"}, instr0_pc, epc);
        chk({tag, ".frdy"}, {31'd0, fetch_rdy}, {31'd0, efr});
    endtask

    function automatic vec_t mk(logic fl, logic fv, logic [31:0] fd, logic [31:0] fpc,
                                logic rdy, logic ev, logic [31:0] eop, logic ec,
                                logic [31:0] epc, logic efr);
        vec_t v;
        v.fl = fl; v.fv = fv; v.fd = fd; v.fpc = fpc; v.rdy = rdy;
        v.ev = ev; v.eop = eop; v.ec = ec; v.epc = epc; v.efr = efr;
        return v;
    endfunction

    initial begin
        logic        ev, ec, efr, c, rfl, rfv, rrdy;
        logic [31:0] eop, rfd, rfpc;
        int          n;

        // directed table: inputs for the cycle, outputs expected before its edge
        tbl.push_back(mk(0,1,32'h00A0_0093,0,1, 0,32'h0,0,32'h00,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 1,32'h00A0_0093,0,32'h00,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 0,32'h0,0,32'h04,1));
        tbl.push_back(mk(0,1,32'h0001_4505,0,1, 0,32'h0,0,32'h04,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 1,32'h0000_4505,1,32'h04,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 1,32'h0000_0001,1,32'h06,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 0,32'h0,0,32'h08,1));
        tbl.push_back(mk(0,1,32'h0093_4505,0,1, 0,32'h0,0,32'h08,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 1,32'h0000_4505,1,32'h08,1));
        tbl.push_back(mk(0,1,32'h0001_00A0,0,1, 0,32'h0,0,32'h0A,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 1,32'h00A0_0093,0,32'h0A,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 1,32'h0000_0001,1,32'h0E,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 0,32'h0,0,32'h10,1));
        tbl.push_back(mk(0,1,32'h00A0_0093,0,0, 0,32'h0,0,32'h10,1));
        tbl.push_back(mk(0,1,32'h00A0_0093,0,0, 1,32'h00A0_0093,0,32'h10,1));
        tbl.push_back(mk(0,1,32'h00A0_0093,0,0, 1,32'h00A0_0093,0,32'h10,1));
        tbl.push_back(mk(0,1,32'h00A0_0093,0,0, 1,32'h00A0_0093,0,32'h10,1));
        tbl.push_back(mk(0,1,32'h0000_0001,0,0, 1,32'h00A0_0093,0,32'h10,0));
        tbl.push_back(mk(0,0,32'h0,0,1, 1,32'h00A0_0093,0,32'h10,0));
        tbl.push_back(mk(0,0,32'h0,0,0, 1,32'h00A0_0093,0,32'h14,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 1,32'h00A0_0093,0,32'h14,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 1,32'h00A0_0093,0,32'h18,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 1,32'h00A0_0093,0,32'h1C,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 0,32'h0,0,32'h20,1));
        tbl.push_back(mk(0,1,32'h00A0_0093,0,0, 0,32'h0,0,32'h20,1));
        tbl.push_back(mk(0,1,32'h00A0_0093,0,0, 1,32'h00A0_0093,0,32'h20,1));
        tbl.push_back(mk(0,1,32'h00A0_0093,0,0, 1,32'h00A0_0093,0,32'h20,1));
        tbl.push_back(mk(1,1,32'h00A0_0093,32'h102,1, 0,32'h0,0,32'h20,1));
        tbl.push_back(mk(0,1,32'h4505_FFFF,0,1, 0,32'h0,0,32'h102,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 1,32'h0000_4505,1,32'h102,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 0,32'h0,0,32'h104,1));

        rst = 1'b1;
        drive(0, 0, 32'h0, 32'h0, 0);
        #12;
        chk_all("reset", 0, 32'h0, 0, 32'h0, 1);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].fl, tbl[i].fv, tbl[i].fd, tbl[i].fpc, tbl[i].rdy);
            #1;
            chk_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].eop, tbl[i].ec,
                    tbl[i].epc, tbl[i].efr);
        end

        // fill buffer, then async reset between edges
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 1, 32'h00A0_0093, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0);
        #1;
        chk("full.frdy", {31'd0, fetch_rdy}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("arst", 0, 32'h0, 0, 32'h0, 1);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 32'h0001_4505, 0, 1);
        #1;
        chk_all("post0", 0, 32'h0, 0, 32'h0, 1);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 1);
        #1;
        chk_all("post1", 1, 32'h0000_4505, 1, 32'h0, 1);
        @(negedge clk);
        #1;
        chk_all("post2", 1, 32'h0000_0001, 1, 32'h2, 1);

        // randomized traffic against the halfword-queue model
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        mq.delete();
        mpc   = 32'h0;
        mskip = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            rfl  = ($urandom_range(0, 40) == 0);
            rfv  = ($urandom_range(0, 3) != 0);
            rrdy = ($urandom_range(0, 3) != 0);
            rfd  = $urandom;
            if ($urandom_range(0, 1) == 1) rfd[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) rfd[17:16] = 2'b11;
            rfpc = $urandom & 32'hFFFF_FFFE;
            drive(rfl, rfv, rfd, rfpc, rrdy);
            efr = (mq.size() <= 2 * DEPTH - 2);
            ev = 0; eop = '0; ec = 0; n = 0;
            if (mq.size() > 0) begin
                c = (mq[0][1:0] != 2'b11);
                n = c ? 1 : 2;
                if (!rfl && mq.size() >= n) begin
                    ev  = 1;
                    ec  = c;
                    eop = c ? {16'h0, mq[0]} : {mq[1], mq[0]};
                end
            end
            #1;
            chk_all($sformatf("rnd%0d", k), ev, eop, ec, mpc, efr);
            @(posedge clk);
            if (rfl) begin
                mq.delete();
                mpc   = rfpc;
                mskip = rfpc[1];
            end else begin
                if (ev && rrdy) begin
                    repeat (n) void'(mq.pop_front());
                    mpc += 32'(2 * n);
                end
                if (rfv && efr) begin
                    if (mskip) begin
                        mq.push_back(rfd[31:16]);
                        mskip = 1'b0;
                    end else begin
                        mq.push_back(rfd[15:0]);
                        mq.push_back(rfd[31:16]);
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
